// File: rtl/board_pkg.sv
// board_pkg: shared geometry constants, the board word type and the fetch
// FSM state encoding for the board fetch arbiter and its grid locator.
package board_pkg;

  localparam int GRID_N   = 10;   // cells per row/column
  localparam int CELL_PX  = 40;   // cell pitch in pixels
  localparam int ORIGIN   = 40;   // grid top-left, same for h and v
  localparam int CELL_W   = 8;    // board word width
  localparam int ADDR_W   = 7;    // RAM address width
  localparam int FETCH_H  = 460;  // hdata column that launches a row burst
  localparam int V_TOTAL  = 525;  // lines per frame
  localparam int GRID_END = ORIGIN + GRID_N * CELL_PX;

  typedef logic [CELL_W-1:0] cell_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // True when a pixel coordinate lies inside the grid span on one axis.
  function automatic logic in_span(input logic [9:0] c);
    return (c >= 10'(ORIGIN)) && (c < 10'(GRID_END));
  endfunction

endpackage

// File: rtl/board_fetch_arbiter_grid_locator.sv
// grid_locator: derives, from the VGA counters, whether the current pixel is
// inside the grid, which cell column it falls in, and when the next line
// starts a new cell row (the burst trigger).
// Ports:
//   clk, rst_n      pixel clock, async active-low reset
//   hdata, vdata    current pixel column / line
//   in_grid         current pixel lies inside the 10x10 grid
//   col_idx         cell column of the current pixel (valid while in_grid)
//   trigger         hdata is at the fetch column and the next line opens a row
//   trig_row        row to fetch, valid with trigger
module grid_locator
  import board_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hdata,
  input  logic [9:0] vdata,
  output logic       in_grid,
  output logic [3:0] col_idx,
  output logic       trigger,
  output logic [3:0] trig_row
);

  logic [5:0] px_q, px_d, px_cur;
  logic [3:0] col_q, col_d;
  logic       at_origin;
  logic [9:0] vnext;
  logic       hit;

  // Position of the current pixel; hdata==ORIGIN restarts both counters so
  // the column index never needs a divider.
  always_comb begin
    at_origin = (hdata == 10'(ORIGIN));
    if (at_origin) begin
      px_cur  = 6'd0;
      col_idx = 4'd0;
    end else begin
      px_cur  = px_q;
      col_idx = col_q;
    end
    in_grid = in_span(hdata) && in_span(vdata);
  end

  // Position of the following pixel; the column saturates past the grid edge.
  always_comb begin
    if (px_cur == 6'(CELL_PX - 1)) begin
      px_d = 6'd0;
      if (col_idx < 4'(GRID_N)) begin
        col_d = col_idx + 4'd1;
      end else begin
        col_d = col_idx;
      end
    end else begin
      px_d  = px_cur + 6'd1;
      col_d = col_idx;
    end
  end

  // Row-start detection: the row is fetched on the line just before it shows.
  always_comb begin
    if (vdata == 10'(V_TOTAL - 1)) begin
      vnext = 10'd0;
    end else begin
      vnext = vdata + 10'd1;
    end
    trigger  = 1'b0;
    trig_row = 4'd0;
    hit      = 1'b0;
    for (int r = 0; r < GRID_N; r++) begin
      hit      = (hdata == 10'(FETCH_H)) && (vnext == 10'(ORIGIN + r * CELL_PX));
      trigger  = trigger | hit;
      trig_row = trig_row | (hit ? 4'(r) : 4'd0);
    end
  end

  // Pixel-within-cell and column counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_q  <= 6'd0;
      col_q <= 4'd0;
    end else begin
      px_q  <= px_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/board_fetch_arbiter.sv
// board_fetch_arbiter: shares the single-port board RAM between the renderer
// and game logic. Before each cell row is displayed, an 11-cycle burst loads
// the row into a 10-entry line buffer; otherwise game-logic requests are
// granted one per req/gnt handshake. The render path returns the buffered
// word for the previous cycle's pixel.
// Ports:
//   clk, rst_n                     pixel clock, async active-low reset
//   hdata, vdata                   VGA pixel column / line
//   ram_addr, ram_we, ram_wdata    board RAM command (registered)
//   ram_rdata                      RAM read data, 1 cycle after address
//   gl_req/gl_we/gl_addr/gl_wdata  game-logic request, held until gl_gnt
//   gl_gnt                         access is on the RAM this cycle
//   gl_rvalid, gl_rdata            read data, 1 cycle after a read grant
//   cell_data, cell_valid          board word / in-grid flag for last pixel
module board_fetch_arbiter
  import board_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        hdata,
  input  logic [9:0]        vdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [CELL_W-1:0] ram_wdata,
  input  logic [CELL_W-1:0] ram_rdata,
  input  logic              gl_req,
  input  logic              gl_we,
  input  logic [ADDR_W-1:0] gl_addr,
  input  logic [CELL_W-1:0] gl_wdata,
  output logic              gl_gnt,
  output logic              gl_rvalid,
  output logic [CELL_W-1:0] gl_rdata,
  output logic [CELL_W-1:0] cell_data,
  output logic              cell_valid
);

  fetch_state_t      state_q, state_d;
  logic [3:0]        bcol_q, bcol_d;
  cell_t             line_buf_q [GRID_N];
  cell_t             line_buf_d [GRID_N];
  logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
  logic              ram_we_q, ram_we_d;
  cell_t             ram_wdata_q, ram_wdata_d;
  logic              gl_gnt_q, gl_gnt_d;
  logic              gl_rvalid_q, gl_rvalid_d;
  cell_t             cell_data_q, cell_data_d;
  logic              cell_valid_q, cell_valid_d;

  logic              in_grid;
  logic [3:0]        col_idx;
  logic              trigger;
  logic [3:0]        trig_row;
  logic [ADDR_W-1:0] row_base;
  logic              grant;

  grid_locator u_locator (
    .clk      (clk),
    .rst_n    (rst_n),
    .hdata    (hdata),
    .vdata    (vdata),
    .in_grid  (in_grid),
    .col_idx  (col_idx),
    .trigger  (trigger),
    .trig_row (trig_row)
  );

  assign row_base = ADDR_W'(trig_row) * ADDR_W'(GRID_N);

  // Fetch FSM, game-logic arbitration and render-path next values.
  always_comb begin
    state_d     = state_q;
    bcol_d      = bcol_q;
    line_buf_d  = line_buf_q;
    ram_addr_d  = ADDR_W'(0);
    ram_we_d    = 1'b0;
    ram_wdata_d = cell_t'(0);
    gl_gnt_d    = 1'b0;
    // A read grant's data arrives on ram_rdata the cycle after the grant.
    gl_rvalid_d = gl_gnt_q && !ram_we_q;

    // Requests may be granted from IDLE (unless a burst starts) and from
    // DRAIN, so a waiting request lands in the first IDLE cycle. gl_gnt_q
    // blocks a second grant while the requester is still dropping gl_req.
    grant = gl_req && !gl_gnt_q &&
            (((state_q == IDLE) && !trigger) || (state_q == DRAIN));

    case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d    = BURST;
          bcol_d     = 4'd0;
          ram_addr_d = row_base;
        end else begin
          state_d = IDLE;
        end
      end
      BURST: begin
        // ram_rdata holds the word addressed in the previous burst cycle.
        if (bcol_q != 4'd0) begin
          line_buf_d[bcol_q - 4'd1] = ram_rdata;
        end else begin
          line_buf_d = line_buf_q;
        end
        if (bcol_q == 4'(GRID_N - 1)) begin
          state_d = DRAIN;
          bcol_d  = 4'd0;
        end else begin
          bcol_d     = bcol_q + 4'd1;
          ram_addr_d = ram_addr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        line_buf_d[GRID_N-1] = ram_rdata;
        state_d              = IDLE;
      end
      default: begin
        state_d = IDLE;
        bcol_d  = 4'd0;
      end
    endcase

    if (grant) begin
      ram_addr_d  = gl_addr;
      ram_we_d    = gl_we;
      ram_wdata_d = gl_we ? gl_wdata : cell_t'(0);
      gl_gnt_d    = 1'b1;
    end else begin
      gl_gnt_d = 1'b0;
    end

    cell_valid_d = in_grid;
    if (in_grid && (col_idx < 4'(GRID_N))) begin
      cell_data_d = line_buf_q[col_idx];
    end else begin
      cell_data_d = cell_t'(0);
    end
  end

  // All arbiter state, line buffer and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      bcol_q       <= 4'd0;
      line_buf_q   <= '{default: cell_t'(0)};
      ram_addr_q   <= ADDR_W'(0);
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= cell_t'(0);
      gl_gnt_q     <= 1'b0;
      gl_rvalid_q  <= 1'b0;
      cell_data_q  <= cell_t'(0);
      cell_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bcol_q       <= bcol_d;
      line_buf_q   <= line_buf_d;
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      ram_wdata_q  <= ram_wdata_d;
      gl_gnt_q     <= gl_gnt_d;
      gl_rvalid_q  <= gl_rvalid_d;
      cell_data_q  <= cell_data_d;
      cell_valid_q <= cell_valid_d;
    end
  end

  assign ram_addr   = ram_addr_q;
  assign ram_we     = ram_we_q;
  assign ram_wdata  = ram_wdata_q;
  assign gl_gnt     = gl_gnt_q;
  assign gl_rvalid  = gl_rvalid_q;
  // The RAM already returns data one cycle after the address, which is
  // exactly the gl_rvalid cycle, so read data is forwarded, gated by valid.
  assign gl_rdata   = gl_rvalid_q ? ram_rdata : cell_t'(0);
  assign cell_data  = cell_data_q;
  assign cell_valid = cell_valid_q;

endmodule

// File: tb/tb_board_fetch_arbiter.sv
module tb_board_fetch_arbiter;
  import board_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [9:0]        hdata = 10'd0;
  logic [9:0]        vdata = 10'd0;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [CELL_W-1:0] ram_wdata;
  logic [CELL_W-1:0] ram_rdata = 8'd0;
  logic              gl_req = 1'b0;
  logic              gl_we = 1'b0;
  logic [ADDR_W-1:0] gl_addr = 7'd0;
  logic [CELL_W-1:0] gl_wdata = 8'd0;
  logic              gl_gnt;
  logic              gl_rvalid;
  logic [CELL_W-1:0] gl_rdata;
  logic [CELL_W-1:0] cell_data;
  logic              cell_valid;

  board_fetch_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hdata      (hdata),
    .vdata      (vdata),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_wdata  (ram_wdata),
    .ram_rdata  (ram_rdata),
    .gl_req     (gl_req),
    .gl_we      (gl_we),
    .gl_addr    (gl_addr),
    .gl_wdata   (gl_wdata),
    .gl_gnt     (gl_gnt),
    .gl_rvalid  (gl_rvalid),
    .gl_rdata   (gl_rdata),
    .cell_data  (cell_data),
    .cell_valid (cell_valid)
  );

  always #5 clk = ~clk;

  // Synchronous single-port board RAM: data 1 cycle after the address.
  logic [7:0] mem [128];
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  logic [31:0] cyc = 32'd0;
  always @(posedge clk) cyc <= cyc + 32'd1;

  typedef struct packed {
    logic [31:0] stamp;
    logic        we;
    logic [6:0]  addr;
    logic [7:0]  data;
  } ev_t;

  ev_t gnt_q[$];
  ev_t rv_q[$];
  ev_t adr_q[$];
  ev_t pix_q[$];

  logic [7:0] ref_mem [128];
  logic [7:0] exp_buf [10];
  int  n_tests = 0;
  int  n_fail = 0;
  bit  mon_on = 1'b0;
  bit  gnt_seen = 1'b0;

  function automatic ev_t mk(input logic [31:0] s, input logic w,
                             input logic [6:0] a, input logic [7:0] d);
    return {s, w, a, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops each expectation in the cycle it is stamped for.
  initial begin
    ev_t e;
    bit  eg, er;
    forever begin
      @(negedge clk);
      if (mon_on && rst_n) begin
        eg = (gnt_q.size() > 0) && (gnt_q[0].stamp == cyc);
        check("gl_gnt", {31'd0, gl_gnt}, {31'd0, eg});
        if (eg) begin
          e = gnt_q.pop_front();
          check("gnt_ram_we", {31'd0, ram_we}, {31'd0, e.we});
          check("gnt_ram_addr", {25'd0, ram_addr}, {25'd0, e.addr});
          if (e.we) check("gnt_ram_wdata", {24'd0, ram_wdata}, {24'd0, e.data});
        end
        er = (rv_q.size() > 0) && (rv_q[0].stamp == cyc);
        check("gl_rvalid", {31'd0, gl_rvalid}, {31'd0, er});
        if (er) begin
          e = rv_q.pop_front();
          check("gl_rdata", {24'd0, gl_rdata}, {24'd0, e.data});
        end
        if ((adr_q.size() > 0) && (adr_q[0].stamp == cyc)) begin
          e = adr_q.pop_front();
          check("burst_addr", {25'd0, ram_addr}, {25'd0, e.addr});
          check("burst_we", {31'd0, ram_we}, 32'd0);
        end
        if ((pix_q.size() > 0) && (pix_q[0].stamp == cyc)) begin
          e = pix_q.pop_front();
          check("cell_valid", {31'd0, cell_valid}, {31'd0, e.we});
          check("cell_data", {24'd0, cell_data}, {24'd0, e.data});
        end
      end
    end
  end

  // One clock step; the requester drops gl_req after its grant cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (gl_req && gnt_seen) begin
      gl_req   = 1'b0;
      gnt_seen = 1'b0;
    end else if (gl_gnt) begin
      gnt_seen = 1'b1;
    end
  endtask

  // Sweep one line over [h0,h1]; optionally raise a read of 33 at req_h.
  task automatic sweep(input int v, input int h0, input int h1, input int req_h);
    int  vn, row;
    bit  trig, pv;
    logic [7:0] pd;
    for (int h = h0; h <= h1; h++) begin
      tick();
      hdata = 10'(h);
      vdata = 10'(v);
      vn   = (v == 524) ? 0 : v + 1;
      trig = (h == 460) && (vn >= 40) && (vn < 440) && (((vn - 40) % 40) == 0);
      if (trig) begin
        row = (vn - 40) / 40;
        for (int c = 0; c < 10; c++) begin
          adr_q.push_back(mk(cyc + 32'(1 + c), 1'b0, 7'(row * 10 + c), 8'd0));
          exp_buf[c] = ref_mem[row * 10 + c];
        end
      end
      pv = (h >= 40) && (h < 440) && (v >= 40) && (v < 440);
      pd = pv ? exp_buf[(h - 40) / 40] : 8'd0;
      pix_q.push_back(mk(cyc + 32'd1, pv, 7'd0, pd));
      if (h == req_h) begin
        gl_req  = 1'b1;
        gl_we   = 1'b0;
        gl_addr = 7'd33;
        gnt_q.push_back(mk(cyc + (trig ? 32'd12 : 32'd1), 1'b0, 7'd33, 8'd0));
        rv_q.push_back(mk(cyc + (trig ? 32'd13 : 32'd2), 1'b0, 7'd33, ref_mem[33]));
      end
    end
  endtask

  task automatic gl_access(input logic we, input logic [6:0] a, input logic [7:0] d);
    tick();
    gl_req   = 1'b1;
    gl_we    = we;
    gl_addr  = a;
    gl_wdata = d;
    gnt_q.push_back(mk(cyc + 32'd1, we, a, d));
    if (we) ref_mem[a] = d;
    else rv_q.push_back(mk(cyc + 32'd2, 1'b0, a, ref_mem[a]));
    for (int i = 0; i < 40 && gl_req; i++) tick();
    if (gl_req) begin
      check("gl_handshake_timeout", 32'd1, 32'd0);
      gl_req = 1'b0;
    end
    tick();
    tick();
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_ram_addr"},   {25'd0, ram_addr},   32'd0);
    check({tag, "_ram_we"},     {31'd0, ram_we},     32'd0);
    check({tag, "_ram_wdata"},  {24'd0, ram_wdata},  32'd0);
    check({tag, "_gl_gnt"},     {31'd0, gl_gnt},     32'd0);
    check({tag, "_gl_rvalid"},  {31'd0, gl_rvalid},  32'd0);
    check({tag, "_gl_rdata"},   {24'd0, gl_rdata},   32'd0);
    check({tag, "_cell_data"},  {24'd0, cell_data},  32'd0);
    check({tag, "_cell_valid"}, {31'd0, cell_valid}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      mem[i]     = 8'(i);
      ref_mem[i] = 8'(i);
    end
    for (int c = 0; c < 10; c++) exp_buf[c] = 8'd0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    tick();
    rst_n  = 1'b1;
    mon_on = 1'b1;

    // Row 0 fetched on line 39, rendered on line 40
    sweep(39, 440, 480, -1);
    sweep(40, 0, 459, -1);
    // Row 2 fetched on line 119, rendered on line 120
    sweep(119, 440, 480, -1);
    sweep(120, 0, 459, -1);

    // Game-logic write then read-back of address 33
    gl_access(1'b1, 7'd33, 8'hAB);
    gl_access(1'b0, 7'd33, 8'h00);

    // Request on the trigger cycle waits out the 11-cycle burst
    sweep(79, 440, 480, 460);
    sweep(80, 0, 459, -1);

    // Reset in the 5th burst cycle
    sweep(159, 440, 465, -1);
    mon_on = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_outputs_zero("midburst_rst");
    gnt_q.delete();
    rv_q.delete();
    adr_q.delete();
    pix_q.delete();
    for (int c = 0; c < 10; c++) exp_buf[c] = 8'd0;
    gnt_seen = 1'b0;
    hdata = 10'd466;
    tick();
    tick();
    rst_n  = 1'b1;
    mon_on = 1'b1;
    gl_access(1'b0, 7'd7, 8'h00);
    sweep(170, 0, 459, -1);
    sweep(199, 440, 480, -1);
    sweep(200, 0, 459, -1);

    // No trigger at frame wrap nor below the grid: immediate grants
    sweep(524, 440, 480, 460);
    sweep(439, 440, 480, 460);

    repeat (4) tick();
    check("queues_drained", 32'(gnt_q.size() + rv_q.size() + adr_q.size() + pix_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/board_fetch_arbiter.md
Name: board_fetch_arbiter

Overview:
- Shares the single-port board-state RAM (one word per grid cell) between the VGA renderer and the game-logic engine.
- Before each cell row is drawn, runs a 10-read burst that loads that row into an internal line buffer.
- Drives the current pixel's cell word to the grid painter, which overlays it on the 40 px grid (origin 40,40; 10x10 cells).
- Outside bursts, grants the game logic RAM access through a req/gnt handshake.

Parameters:
- GRID_N, 10, cells per row/column
- CELL_PX, 40, cell pitch in pixels
- ORIGIN, 40, grid top-left pixel coordinate, same value for h and v
- CELL_W, 8, board word width
- ADDR_W, 7, RAM address width; must satisfy 2^ADDR_W >= GRID_N*GRID_N
- FETCH_H, 460, hdata value that triggers a burst; must satisfy ORIGIN+GRID_N*CELL_PX <= FETCH_H and FETCH_H+GRID_N+1 < H_TOTAL
- V_TOTAL, 525, lines per frame, used for vdata wrap

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  asynchronous, active-low reset
- hdata  in  10  current pixel column from the VGA timing generator
- vdata  in  10  current line from the VGA timing generator
- ram_addr  out  ADDR_W  board RAM address
- ram_we  out  1  board RAM write enable
- ram_wdata  out  CELL_W  board RAM write data
- ram_rdata  in  CELL_W  board RAM read data, valid 1 cycle after the address
- gl_req  in  1  game-logic access request; held with gl_we/gl_addr/gl_wdata stable until gl_gnt
- gl_we  in  1  1 = write, 0 = read
- gl_addr  in  ADDR_W  game-logic address
- gl_wdata  in  CELL_W  game-logic write data
- gl_gnt  out  1  pulses for the cycle in which the access is driven onto the RAM
- gl_rvalid  out  1  pulses 1 cycle after a read grant
- gl_rdata  out  CELL_W  read data, valid with gl_rvalid
- cell_data  out  CELL_W  board word for the pixel at the previous cycle's hdata/vdata
- cell_valid  out  1  the previous-cycle pixel lies inside the grid area

Behaviour:
- Reset, applied asynchronously:
  - state IDLE
  - all 10 line-buffer entries 0
  - outputs 0: ram_we, gl_gnt, gl_rvalid, gl_rdata, cell_data, cell_valid, ram_addr, ram_wdata
- vnext = (vdata == V_TOTAL-1) ? 0 : vdata+1.
- Trigger fires when all of the following hold:
  - hdata == FETCH_H
  - ORIGIN <= vnext < ORIGIN+GRID_N*CELL_PX
  - (vnext-ORIGIN) % CELL_PX == 0
- Fetched row = (vnext-ORIGIN)/CELL_PX. The row is therefore fetched on the last line before it is displayed.
- State IDLE:
  - On trigger, go to BURST with col=0. The trigger has priority over gl_req that cycle (no grant).
  - Otherwise, if gl_req: drive gl_addr/gl_we/gl_wdata to the RAM and assert gl_gnt for 1 cycle.
  - After a read grant, assert gl_rvalid next cycle with gl_rdata = ram_rdata.
  - A write completes in the grant cycle.
- State BURST:
  - Each cycle drive ram_addr = row*GRID_N+col with ram_we=0.
  - Capture ram_rdata into buf[col-1] when col>0; increment col.
  - After col==GRID_N-1 is issued, go to DRAIN.
- State DRAIN: capture buf[GRID_N-1], then return to IDLE.
  - A burst takes GRID_N+1 = 11 cycles.
  - gl_gnt is 0 throughout BURST/DRAIN. A pending gl_req waits and is granted in the first IDLE cycle.
- A gl_rvalid due from a grant in the cycle before a burst still asserts; the burst's first capture is buf[0], taken one cycle later, so there is no conflict.
- Render path, registered with 1-cycle latency:
  - cell_valid <= ORIGIN <= hdata < ORIGIN+GRID_N*CELL_PX and ORIGIN <= vdata < ORIGIN+GRID_N*CELL_PX.
  - cell_data <= cell_valid_next ? buf[(hdata-ORIGIN)/CELL_PX] : 0.
  - Use a compare/count column index, not a general divider: a 6-bit pixel counter plus a 4-bit column counter reset at hdata==ORIGIN.
- Game writes to a row already buffered become visible at that row's next fetch, i.e. the next frame. This is accepted.
- Reset mid-burst aborts the burst to IDLE and clears the buffer; the next trigger refetches.
- hdata/vdata are never out of range; no behaviour is required for hdata >= H_TOTAL.

Decomposition:
- Package board_pkg holds:
  - GRID_N, CELL_PX, ORIGIN, CELL_W, ADDR_W
  - typedef cell_t (logic[CELL_W-1:0])
  - typedef fetch_state_t enum {IDLE, BURST, DRAIN}
- One sub-module, grid_locator: combinational plus counters, producing in_grid, col index and row-start trigger from hdata/vdata. The arbiter FSM and line buffer stay in the top module.

Test Plan:
- Preload RAM[i]=i. At vdata=39, hdata=460: ram_addr steps 0..9 over 10 cycles and buf ends {0..9}. Line 40 at hdata=45 gives cell_data=0 and cell_valid=1; at hdata=85, cell_data=1; at hdata=439, cell_data=9; at hdata=440, cell_valid=0.
- At vdata=119, hdata=460: addresses 20..29 are read. During line 120, hdata=200 gives cell_data=24.
- gl_req write addr 33, data 0xAB, in IDLE: gl_gnt, ram_we=1, ram_addr=33 in the same cycle. Then a read of 33 gives gl_rvalid next cycle with gl_rdata=0xAB.
- gl_req asserted on the trigger cycle (vdata=79, hdata=460): gl_gnt stays 0 for 11 cycles and pulses on cycle 12. buf holds row 1 intact.
- rst_n low at burst cycle 5: all outputs go to 0 at once, buf is all 0 and state is IDLE. The next trigger runs a full 11-cycle burst.
- vdata=524 wraps to 0 (no trigger). At vdata=439, hdata=460: no trigger, since vnext=440 is outside the grid.
